// File: rtl/ad7864_pkg.sv
// Shared definitions for the AD7864 readout sequencer: FSM states, word layout, word assembly.
// Optional feature macro: AD7864_PARITY_EN (even parity in word bit 12).
package ad7864_pkg;

    localparam int WORD_W  = 16;
    localparam int CH_MSB  = 15;
    localparam int CH_LSB  = 14;
    localparam int PAR_BIT = 12;
    localparam int DATA_W  = 12;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_EOC  = 3'd3,
        S_READ      = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_SEND      = 3'd6
    } state_e;

    function automatic logic [WORD_W-1:0] make_word(input logic [1:0] ch,
                                                    input logic [DATA_W-1:0] code);
        logic [WORD_W-1:0] w;
        w = '0;
        w[CH_MSB:CH_LSB] = ch;
        w[DATA_W-1:0]    = code;
`ifdef AD7864_PARITY_EN
        // bit 12 is still zero here, so the XOR of the rest makes the total even
        w[PAR_BIT] = ^w;
`else
        w[PAR_BIT] = 1'b0;
`endif
        return w;
    endfunction

endpackage

// File: rtl/ad7864_spi_shift_tx.sv
// SPI mode-0 burst transmitter: loads a frame on start, shifts MSB first, pulses done when spi_cs rises.
module spi_shift_tx #(
    parameter int NBITS   = 64,
    parameter int CLK_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] data,
    output logic             spi_cs,
    output logic             spi_clk,
    output logic             spi_mosi,
    output logic             done
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(NBITS + 1);

    logic [NBITS-1:0] sh_q, sh_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             cs_q, cs_d, clk_q, clk_d, mosi_q, mosi_d, tail_q, tail_d, done_q, done_d;

    always_comb begin
        sh_d   = sh_q;
        div_d  = div_q;
        bit_d  = bit_q;
        cs_d   = cs_q;
        clk_d  = clk_q;
        mosi_d = mosi_q;
        tail_d = tail_q;
        done_d = 1'b0;
        if (cs_q) begin
            if (start) begin
                cs_d   = 1'b0;
                sh_d   = data;
                mosi_d = data[NBITS-1];
                div_d  = '0;
                bit_d  = '0;
                clk_d  = 1'b0;
                tail_d = 1'b0;
            end
        end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d = '0;
            if (tail_q) begin
                // trailing half-period after the last falling edge closes the frame
                cs_d   = 1'b1;
                done_d = 1'b1;
            end else if (!clk_q) begin
                clk_d = 1'b1;
            end else begin
                clk_d = 1'b0;
                bit_d = bit_q + 1'b1;
                if (bit_q == BIT_W'(NBITS - 1)) begin
                    tail_d = 1'b1;
                    mosi_d = 1'b0;
                end else begin
                    sh_d   = sh_q << 1;
                    mosi_d = sh_q[NBITS-2];
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            div_q  <= '0;
            bit_q  <= '0;
            cs_q   <= 1'b1;
            clk_q  <= 1'b0;
            mosi_q <= 1'b0;
            tail_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            cs_q   <= cs_d;
            clk_q  <= clk_d;
            mosi_q <= mosi_d;
            tail_q <= tail_d;
            done_q <= done_d;
        end
    end

    assign spi_cs   = cs_q;
    assign spi_clk  = clk_q;
    assign spi_mosi = mosi_q;
    assign done     = done_q;

endmodule

// File: rtl/ad7864_readout.sv
// AD7864 conversion/readout sequencer feeding one framed SPI burst per conversion to the DSP.
// Optional feature macro: AD7864_PARITY_EN (handled in ad7864_pkg::make_word).
module ad7864_readout
    import ad7864_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int RD_CYC  = 3,
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        conv_req,
    output logic        convst_n,
    output logic        cs_n,
    output logic        rd_n,
    input  logic        busy,
    input  logic        eoc_n,
    input  logic [11:0] db,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        overrun,
    output logic        timeout
);
    localparam int CNT_MAX = (TIMEOUT > RD_CYC) ? TIMEOUT : RD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FRAME_W = NUM_CH * WORD_W;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [2:0]                     ch_q, ch_d;
    logic [NUM_CH-1:0][WORD_W-1:0]  buf_q, buf_d;
    logic                           convst_n_q, convst_n_d, rd_n_q, rd_n_d;
    logic                           overrun_q, overrun_d, timeout_q, timeout_d;
    logic                           req_q, req_prev_q;
    logic                           busy_m_q, busy_s_q;
    logic                           eoc_m_q, eoc_s_q, eoc_prev_q;
    logic                           req_edge, eoc_fall, start_tx, tx_done;
    logic [FRAME_W-1:0]             frame;

    assign req_edge = req_q & ~req_prev_q;
    assign eoc_fall = eoc_prev_q & ~eoc_s_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        buf_d      = buf_q;
        convst_n_d = convst_n_q;
        rd_n_d     = rd_n_q;
        overrun_d  = req_edge && (state_q != S_IDLE);
        timeout_d  = 1'b0;
        start_tx   = 1'b0;
        case (state_q)
            S_IDLE: if (req_edge) begin
                state_d    = S_START;
                ch_d       = '0;
                cnt_d      = '0;
                convst_n_d = 1'b0;
            end
            S_START: if (cnt_q == CNT_W'(1)) begin
                convst_n_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT_BUSY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_WAIT_BUSY: if (busy_s_q) begin
                state_d = S_WAIT_EOC;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_WAIT_EOC: if (eoc_fall) begin
                rd_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_READ;
            end
            S_READ: if (cnt_q == CNT_W'(RD_CYC - 1)) begin
                // db is captured on the edge closing the last low cycle of rd_n
                rd_n_d = 1'b1;
                for (int i = 0; i < NUM_CH; i++)
                    if (ch_q == 3'(i)) buf_d[i] = make_word(ch_q[1:0], db);
                ch_d    = ch_q + 1'b1;
                state_d = (ch_q == 3'(NUM_CH - 1)) ? S_WAIT_DONE : S_WAIT_EOC;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_WAIT_DONE: if (!busy_s_q) begin
                start_tx = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ch_q       <= '0;
            buf_q      <= '0;
            convst_n_q <= 1'b1;
            rd_n_q     <= 1'b1;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            busy_m_q   <= 1'b0;
            busy_s_q   <= 1'b0;
            eoc_m_q    <= 1'b1;
            eoc_s_q    <= 1'b1;
            eoc_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            buf_q      <= buf_d;
            convst_n_q <= convst_n_d;
            rd_n_q     <= rd_n_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            req_q      <= conv_req;
            req_prev_q <= req_q;
            busy_m_q   <= busy;
            busy_s_q   <= busy_m_q;
            eoc_m_q    <= eoc_n;
            eoc_s_q    <= eoc_m_q;
            eoc_prev_q <= eoc_s_q;
        end
    end

    // channel 0 occupies the most significant word so it leaves first
    always_comb begin
        frame = '0;
        for (int i = 0; i < NUM_CH; i++)
            frame[(NUM_CH-1-i)*WORD_W +: WORD_W] = buf_q[i];
    end

    spi_shift_tx #(
        .NBITS  (FRAME_W),
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .start   (start_tx),
        .data    (frame),
        .spi_cs  (spi_cs),
        .spi_clk (spi_clk),
        .spi_mosi(spi_mosi),
        .done    (tx_done)
    );

    assign convst_n = convst_n_q;
    assign cs_n     = rd_n_q;
    assign rd_n     = rd_n_q;
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_ad7864_readout.sv
// Directed bench for ad7864_readout: default instance (4 ch) and a minimal instance (1 ch, fast SPI).
module tb_ad7864_readout;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [1:0]  conv_req, busy, eoc_n;
    logic [11:0] db [2];
    wire  [1:0]  convst_n, cs_n, rd_n, spi_cs, spi_clk, spi_mosi, overrun, timeout;

    always #5 clk_in = ~clk_in;

    ad7864_readout u_dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .conv_req(conv_req[0]), .convst_n(convst_n[0]),
        .cs_n(cs_n[0]), .rd_n(rd_n[0]), .busy(busy[0]), .eoc_n(eoc_n[0]), .db(db[0]),
        .spi_cs(spi_cs[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]),
        .overrun(overrun[0]), .timeout(timeout[0])
    );

    ad7864_readout #(.NUM_CH(1), .RD_CYC(2), .CLK_DIV(1), .TIMEOUT(255)) u_dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .conv_req(conv_req[1]), .convst_n(convst_n[1]),
        .cs_n(cs_n[1]), .rd_n(rd_n[1]), .busy(busy[1]), .eoc_n(eoc_n[1]), .db(db[1]),
        .spi_cs(spi_cs[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]),
        .overrun(overrun[1]), .timeout(timeout[1])
    );

    int checks = 0;
    int errors = 0;
    int ovr_cnt [2] = '{0, 0};
    int tmo_cnt [2] = '{0, 0};
    int frm_cnt [2] = '{0, 0};
    logic [1:0] cs_prev = 2'b11;

    always @(negedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (overrun[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
            if (timeout[i] === 1'b1) tmo_cnt[i] <= tmo_cnt[i] + 1;
            if (cs_prev[i] === 1'b1 && spi_cs[i] === 1'b0) frm_cnt[i] <= frm_cnt[i] + 1;
        end
        cs_prev <= spi_cs;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ADC model: request, observe CONVST, raise busy, strobe eoc_n per channel, serve db on rd_n.
    task automatic adc_run(input int d, input int nch, input int rdcyc, input logic [3:0][11:0] codes,
                           input bit raise_busy, output int cv_lat, output int cv_low,
                           output int rd_bad, output bit ok);
        int n;
        ok = 1'b1; rd_bad = 0; cv_low = 0; cv_lat = 0;
        @(negedge clk_in); conv_req[d] = 1'b1;
        @(negedge clk_in); conv_req[d] = 1'b0;
        while (convst_n[d] === 1'b1 && cv_lat < 10) begin @(negedge clk_in); cv_lat++; end
        if (convst_n[d] !== 1'b0) begin ok = 1'b0; return; end
        while (convst_n[d] === 1'b0 && cv_low < 10) begin @(negedge clk_in); cv_low++; end
        if (!raise_busy) return;
        repeat (2) @(negedge clk_in);
        busy[d] = 1'b1;
        for (int c = 0; c < nch; c++) begin
            repeat (3) @(negedge clk_in);
            db[d] = codes[c];
            eoc_n[d] = 1'b0;
            n = 0;
            while (rd_n[d] === 1'b1 && n < 20) begin
                @(negedge clk_in); n++;
                if (n == 2) eoc_n[d] = 1'b1;
            end
            eoc_n[d] = 1'b1;
            if (rd_n[d] !== 1'b0) begin ok = 1'b0; busy[d] = 1'b0; return; end
            if (n != 3) rd_bad++;
            n = 0;
            while (rd_n[d] === 1'b0 && n < 20) begin
                if (cs_n[d] !== 1'b0) rd_bad++;
                @(negedge clk_in); n++;
            end
            if (n != rdcyc || cs_n[d] !== 1'b1) rd_bad++;
            db[d] = ~codes[c];
        end
        repeat (3) @(negedge clk_in);
        busy[d] = 1'b0;
    endtask

    // SPI receiver: samples mosi on spi_clk rise, checks half-period spacing and mosi stability.
    task automatic capture(input int d, input int cd, output logic [63:0] frame, output int nbits,
                           output int terr, output logic first_bit, output bit got);
        int t, n, last_rise, last_fall;
        logic pclk, pmosi;
        frame = '0; nbits = 0; terr = 0; got = 1'b0; first_bit = 1'b0;
        n = 0;
        while (spi_cs[d] === 1'b1 && n < 200) begin @(negedge clk_in); n++; end
        if (spi_cs[d] !== 1'b0) return;
        got = 1'b1; first_bit = spi_mosi[d];
        pclk = spi_clk[d]; pmosi = spi_mosi[d];
        if (pclk !== 1'b0) terr++;
        t = 0; last_rise = 0; last_fall = 0;
        while (t < 5000) begin
            @(negedge clk_in); t++;
            if (spi_cs[d] === 1'b1) break;
            if (spi_clk[d] === 1'b1 && pclk === 1'b0) begin
                frame = {frame[62:0], spi_mosi[d]};
                nbits++;
                if (t - last_rise != ((nbits == 1) ? cd : 2 * cd)) terr++;
                last_rise = t;
            end
            if (spi_clk[d] === 1'b0 && pclk === 1'b1) last_fall = t;
            else if (spi_mosi[d] !== pmosi) terr++;
            pclk = spi_clk[d]; pmosi = spi_mosi[d];
        end
        if (spi_cs[d] !== 1'b1 || t - last_fall != cd) terr++;
    endtask

    task automatic run_vec(input string nm, input int d, input int nch, input int rdcyc, input int cd,
                           input logic [3:0][11:0] codes, input logic [63:0] exp);
        int cv_lat, cv_low, rd_bad, nb, terr;
        bit ok, got;
        logic fb;
        logic [63:0] fr;
        adc_run(d, nch, rdcyc, codes, 1'b1, cv_lat, cv_low, rd_bad, ok);
        check($sformatf("%s_adc_seq", nm), 64'(ok), 64'd1);
        check($sformatf("%s_convst_lat", nm), 64'(cv_lat), 64'd1);
        check($sformatf("%s_convst_low", nm), 64'(cv_low), 64'd2);
        check($sformatf("%s_rd_timing", nm), 64'(rd_bad), 64'd0);
        capture(d, cd, fr, nb, terr, fb, got);
        check($sformatf("%s_frame_seen", nm), 64'(got), 64'd1);
        check($sformatf("%s_first_bit", nm), 64'(fb), 64'(exp[nch*16-1]));
        check($sformatf("%s_nbits", nm), 64'(nb), 64'(nch * 16));
        check($sformatf("%s_spi_timing", nm), 64'(terr), 64'd0);
        check($sformatf("%s_frame", nm), fr, exp);
    endtask

    typedef struct packed {
        logic [3:0][11:0] c;
        logic [63:0]      exp;
    } vec_t;

    vec_t vt [4];

    initial begin
        int cv_lat, cv_low, rd_bad, nb, terr, k, n, fr0, ov0;
        bit ok, got;
        logic fb, pclk;
        logic [63:0] fr;

        vt[0].c = {12'hABC, 12'h789, 12'h456, 12'h123};
        vt[1].c = {12'h000, 12'hFFF, 12'h003, 12'h001};
        vt[2].c = {12'h000, 12'h000, 12'h000, 12'h003};
        vt[3].c = {12'hAAA, 12'h555, 12'h800, 12'hFFF};
`ifdef AD7864_PARITY_EN
        vt[0].exp = 64'h0123_4456_9789_DABC;
        vt[1].exp = 64'h1001_5003_9FFF_C000;
        vt[2].exp = 64'h0003_5000_9000_C000;
        vt[3].exp = 64'h0FFF_4800_9555_CAAA;
`else
        vt[0].exp = 64'h0123_4456_8789_CABC;
        vt[1].exp = 64'h0001_4003_8FFF_C000;
        vt[2].exp = 64'h0003_4000_8000_C000;
        vt[3].exp = 64'h0FFF_4800_8555_CAAA;
`endif

        rst_n = 1'b0; conv_req = 2'b00; busy = 2'b00; eoc_n = 2'b11;
        db[0] = 12'h000; db[1] = 12'h000;
        repeat (3) @(negedge clk_in);
        check("rst_convst_n", 64'(convst_n[0]), 64'd1);
        check("rst_cs_n",     64'(cs_n[0]),     64'd1);
        check("rst_rd_n",     64'(rd_n[0]),     64'd1);
        check("rst_spi_cs",   64'(spi_cs[0]),   64'd1);
        check("rst_spi_clk",  64'(spi_clk[0]),  64'd0);
        check("rst_spi_mosi", 64'(spi_mosi[0]), 64'd0);
        check("rst_overrun",  64'(overrun[0]),  64'd0);
        check("rst_timeout",  64'(timeout[0]),  64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);

        for (int v = 0; v < 4; v++)
            run_vec($sformatf("vec%0d", v), 0, 4, 3, 2, vt[v].c, vt[v].exp);

        // busy never rises: timeout after TIMEOUT cycles in WAIT_BUSY, no frame
        fr0 = frm_cnt[0];
        adc_run(0, 4, 3, vt[0].c, 1'b0, cv_lat, cv_low, rd_bad, ok);
        check("tmo_convst", 64'(ok), 64'd1);
        k = 0;
        while (timeout[0] !== 1'b1 && k < 400) begin @(negedge clk_in); k++; end
        check("tmo_cycles", 64'(k), 64'd255);
        @(negedge clk_in);
        check("tmo_pulse_width", 64'(timeout[0]), 64'd0);
        repeat (20) @(negedge clk_in);
        check("tmo_no_frame", 64'(frm_cnt[0] - fr0), 64'd0);
        check("tmo_spi_cs", 64'(spi_cs[0]), 64'd1);
        check("tmo_count", 64'(tmo_cnt[0]), 64'd1);
        run_vec("after_tmo", 0, 4, 3, 2, vt[1].c, vt[1].exp);

        // conv_req during SEND: one overrun pulse, frame intact, no second frame
        fr0 = frm_cnt[0]; ov0 = ovr_cnt[0];
        adc_run(0, 4, 3, vt[2].c, 1'b1, cv_lat, cv_low, rd_bad, ok);
        check("ovr_adc_seq", 64'(ok), 64'd1);
        fork
            capture(0, 2, fr, nb, terr, fb, got);
            begin
                n = 0;
                while (spi_cs[0] === 1'b1 && n < 200) begin @(negedge clk_in); n++; end
                repeat (30) @(negedge clk_in);
                conv_req[0] = 1'b1;
                @(negedge clk_in);
                conv_req[0] = 1'b0;
            end
        join
        check("ovr_frame", fr, vt[2].exp);
        check("ovr_nbits", 64'(nb), 64'd64);
        check("ovr_spi_timing", 64'(terr), 64'd0);
        repeat (100) @(negedge clk_in);
        check("ovr_pulses", 64'(ovr_cnt[0] - ov0), 64'd1);
        check("ovr_one_frame", 64'(frm_cnt[0] - fr0), 64'd1);

        // reset in the middle of a frame
        adc_run(0, 4, 3, vt[0].c, 1'b1, cv_lat, cv_low, rd_bad, ok);
        check("rstmid_adc_seq", 64'(ok), 64'd1);
        n = 0;
        while (spi_cs[0] === 1'b1 && n < 200) begin @(negedge clk_in); n++; end
        nb = 0; pclk = 1'b0; n = 0;
        while (nb < 20 && n < 3000) begin
            @(negedge clk_in); n++;
            if (spi_clk[0] === 1'b1 && pclk === 1'b0) nb++;
            pclk = spi_clk[0];
        end
        check("rstmid_bit20", 64'(nb), 64'd20);
        rst_n = 1'b0;
        #1;
        check("rstmid_spi_cs", 64'(spi_cs[0]), 64'd1);
        check("rstmid_spi_clk", 64'(spi_clk[0]), 64'd0);
        check("rstmid_spi_mosi", 64'(spi_mosi[0]), 64'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        run_vec("after_rst", 0, 4, 3, 2, vt[3].c, vt[3].exp);

        // minimal configuration: 1 channel, RD_CYC=2, CLK_DIV=1
`ifdef AD7864_PARITY_EN
        run_vec("min_cfg", 1, 1, 2, 1, {12'h000, 12'h000, 12'h000, 12'hABC}, 64'h1ABC);
`else
        run_vec("min_cfg", 1, 1, 2, 1, {12'h000, 12'h000, 12'h000, 12'hABC}, 64'h0ABC);
`endif

        repeat (10) @(negedge clk_in);
        check("total_overrun0", 64'(ovr_cnt[0]), 64'd1);
        check("total_timeout0", 64'(tmo_cnt[0]), 64'd1);
        check("total_overrun1", 64'(ovr_cnt[1]), 64'd0);
        check("total_timeout1", 64'(tmo_cnt[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
